// File: rtl/i281_isa_pkg.sv
// Shared i281 ISA definitions: one-hot opcode indices, encoding nibbles and
// subcodes, loader error codes and loader FSM state encoding.
package i281_isa_pkg;

    localparam int OP_W = 27;

    // One-hot opcode index order, shared with opcodedec
    localparam int IDX_NOOP    = 0;
    localparam int IDX_INPUTC  = 1;
    localparam int IDX_INPUTCF = 2;
    localparam int IDX_INPUTD  = 3;
    localparam int IDX_INPUTDF = 4;
    localparam int IDX_MOVE    = 5;
    localparam int IDX_LOADI   = 6;
    localparam int IDX_LOADP   = 7;
    localparam int IDX_ADD     = 8;
    localparam int IDX_ADDI    = 9;
    localparam int IDX_SUB     = 10;
    localparam int IDX_SUBI    = 11;
    localparam int IDX_LOAD    = 12;
    localparam int IDX_LOADF   = 13;
    localparam int IDX_STORE   = 14;
    localparam int IDX_STOREF  = 15;
    localparam int IDX_SHIFTL  = 16;
    localparam int IDX_SHIFTR  = 17;
    localparam int IDX_CMP     = 18;
    localparam int IDX_JUMP    = 19;
    localparam int IDX_BRE     = 20;
    localparam int IDX_BRZ     = 21;
    localparam int IDX_BRNE    = 22;
    localparam int IDX_BRNZ    = 23;
    localparam int IDX_BRG     = 24;
    localparam int IDX_BRGE    = 25;
    localparam int IDX_RSVD    = 26;

    localparam logic [3:0] NIB_NOOP   = 4'h0;
    localparam logic [3:0] NIB_INPUT  = 4'h1;
    localparam logic [3:0] NIB_MOVE   = 4'h2;
    localparam logic [3:0] NIB_LOADI  = 4'h3;
    localparam logic [3:0] NIB_ADD    = 4'h4;
    localparam logic [3:0] NIB_ADDI   = 4'h5;
    localparam logic [3:0] NIB_SUB    = 4'h6;
    localparam logic [3:0] NIB_SUBI   = 4'h7;
    localparam logic [3:0] NIB_LOAD   = 4'h8;
    localparam logic [3:0] NIB_LOADF  = 4'h9;
    localparam logic [3:0] NIB_STORE  = 4'hA;
    localparam logic [3:0] NIB_STOREF = 4'hB;
    localparam logic [3:0] NIB_SHIFT  = 4'hC;
    localparam logic [3:0] NIB_CMP    = 4'hD;
    localparam logic [3:0] NIB_JUMP   = 4'hE;
    localparam logic [3:0] NIB_BRANCH = 4'hF;

    localparam logic [1:0] SUB_INPUTC  = 2'b00;
    localparam logic [1:0] SUB_INPUTCF = 2'b01;
    localparam logic [1:0] SUB_INPUTD  = 2'b10;
    localparam logic [1:0] SUB_INPUTDF = 2'b11;
    localparam logic [1:0] SUB_LOADI   = 2'b00;
    localparam logic [1:0] SUB_LOADP   = 2'b01;
    localparam logic [1:0] SUB_SHIFTL  = 2'b00;
    localparam logic [1:0] SUB_SHIFTR  = 2'b01;
    localparam logic [1:0] SUB_BRE     = 2'b00;
    localparam logic [1:0] SUB_BRNE    = 2'b01;
    localparam logic [1:0] SUB_BRG     = 2'b10;
    localparam logic [1:0] SUB_BRGE    = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OPCODE   = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_VERIFY   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Exactly one bit set, and not the reserved slot
    function automatic logic onehot_ok(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - OP_W'(1))) == '0) && !op[IDX_RSVD];
    endfunction

endpackage

// File: rtl/opcodeenc.sv
// Combinational i281 instruction encoder: one-hot opcode plus register and
// immediate fields in, 16-bit instruction word and a valid flag out.
module opcodeenc
    import i281_isa_pkg::*;
(
    input  logic [OP_W-1:0] op_onehot,
    input  logic [1:0]      reg_a,
    input  logic [1:0]      reg_b,
    input  logic [7:0]      imm,
    output logic [15:0]     word,
    output logic            valid
);

    int         idx;
    logic [3:0] nib;
    logic [1:0] sub;
    logic       use_a;
    logic       use_b;
    logic       use_imm;

    always_comb begin
        idx = 0;
        for (int i = 0; i < OP_W; i++) begin
            if (op_onehot[i]) idx = i;
        end
    end

    always_comb begin
        nib     = NIB_NOOP;
        sub     = 2'b00;
        use_a   = 1'b0;
        use_b   = 1'b0;
        use_imm = 1'b0;
        case (idx)
            IDX_INPUTC:  begin nib = NIB_INPUT;  sub = SUB_INPUTC;  use_imm = 1'b1; end
            IDX_INPUTCF: begin nib = NIB_INPUT;  sub = SUB_INPUTCF; use_a = 1'b1; use_imm = 1'b1; end
            IDX_INPUTD:  begin nib = NIB_INPUT;  sub = SUB_INPUTD;  use_imm = 1'b1; end
            IDX_INPUTDF: begin nib = NIB_INPUT;  sub = SUB_INPUTDF; use_a = 1'b1; use_imm = 1'b1; end
            IDX_MOVE:    begin nib = NIB_MOVE;   use_a = 1'b1; use_b = 1'b1; end
            IDX_LOADI:   begin nib = NIB_LOADI;  sub = SUB_LOADI; use_a = 1'b1; use_imm = 1'b1; end
            IDX_LOADP:   begin nib = NIB_LOADI;  sub = SUB_LOADP; use_a = 1'b1; use_imm = 1'b1; end
            IDX_ADD:     begin nib = NIB_ADD;    use_a = 1'b1; use_b = 1'b1; end
            IDX_ADDI:    begin nib = NIB_ADDI;   use_a = 1'b1; use_imm = 1'b1; end
            IDX_SUB:     begin nib = NIB_SUB;    use_a = 1'b1; use_b = 1'b1; end
            IDX_SUBI:    begin nib = NIB_SUBI;   use_a = 1'b1; use_imm = 1'b1; end
            IDX_LOAD:    begin nib = NIB_LOAD;   use_a = 1'b1; use_imm = 1'b1; end
            IDX_LOADF:   begin nib = NIB_LOADF;  use_a = 1'b1; use_b = 1'b1; use_imm = 1'b1; end
            IDX_STORE:   begin nib = NIB_STORE;  use_a = 1'b1; use_imm = 1'b1; end
            IDX_STOREF:  begin nib = NIB_STOREF; use_a = 1'b1; use_b = 1'b1; use_imm = 1'b1; end
            IDX_SHIFTL:  begin nib = NIB_SHIFT;  sub = SUB_SHIFTL; use_a = 1'b1; end
            IDX_SHIFTR:  begin nib = NIB_SHIFT;  sub = SUB_SHIFTR; use_a = 1'b1; end
            IDX_CMP:     begin nib = NIB_CMP;    use_a = 1'b1; use_b = 1'b1; end
            IDX_JUMP:    begin nib = NIB_JUMP;   use_imm = 1'b1; end
            IDX_BRE,
            IDX_BRZ:     begin nib = NIB_BRANCH; sub = SUB_BRE;  use_imm = 1'b1; end
            IDX_BRNE,
            IDX_BRNZ:    begin nib = NIB_BRANCH; sub = SUB_BRNE; use_imm = 1'b1; end
            IDX_BRG:     begin nib = NIB_BRANCH; sub = SUB_BRG;  use_imm = 1'b1; end
            IDX_BRGE:    begin nib = NIB_BRANCH; sub = SUB_BRGE; use_imm = 1'b1; end
            default:     ;
        endcase
    end

    assign valid = onehot_ok(op_onehot);

    // Field B slot carries the subcode whenever reg_b is not used
    assign word = valid ? {nib,
                           use_a   ? reg_a : 2'b00,
                           use_b   ? reg_b : sub,
                           use_imm ? imm   : 8'h00} : 16'h0000;

endmodule

// File: rtl/opcodeenc_loader.sv
// Program loader: accepts one instruction per valid/ready handshake, encodes
// it, writes it to code memory at an incrementing address and optionally verifies it.
module opcodeenc_loader
    import i281_isa_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter bit VERIFY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_onehot,
    input  logic              last,
    input  logic [1:0]        reg_a,
    input  logic [1:0]        reg_b,
    input  logic [7:0]        imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count,
    output state_t            state
);

    // Handshake: an instruction is consumed on a rising edge where in_valid
    // and in_ready are both high; in_ready is high only in ACCEPT.
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       enc_word;
    logic              enc_valid;
    logic              last_q;
    logic              mismatch;
    state_t            state_next;

    logic              in_ready_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [15:0]       mem_wdata_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic [1:0]        err_code_d;
    logic [ADDR_W:0]   count_d;
    logic              last_d;

    opcodeenc u_enc (
        .op_onehot (op_onehot),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .imm       (imm),
        .word      (enc_word),
        .valid     (enc_valid)
    );

    assign mismatch = VERIFY && (mem_rdata != mem_wdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            count     <= '0;
            last_q    <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            err_code  <= err_code_d;
            count     <= count_d;
            last_q    <= last_d;
        end
    end

    // start wins over everything, including an instruction offered that cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   state_next = ST_IDLE;
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (!enc_valid)         state_next = ST_ERROR;
                    else if (count == FULL) state_next = ST_ERROR;
                    else                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (VERIFY)      state_next = ST_READ;
                else if (last_q) state_next = ST_IDLE;
                else             state_next = ST_ACCEPT;
            end
            ST_READ:   state_next = ST_CHECK;
            ST_CHECK: begin
                if (mismatch)    state_next = ST_ERROR;
                else if (last_q) state_next = ST_IDLE;
                else             state_next = ST_ACCEPT;
            end
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_IDLE;
        endcase
        if (start) state_next = ST_ACCEPT;
    end

    // Outputs are computed from the upcoming state and registered above
    always_comb begin
        in_ready_d  = (state_next == ST_ACCEPT);
        mem_we_d    = (state_next == ST_WRITE);
        busy_d      = state_next inside {ST_ACCEPT, ST_WRITE, ST_READ, ST_CHECK};
        done_d      = (state_next == ST_IDLE) && (state == ST_WRITE || state == ST_CHECK);
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        last_d      = last_q;
        count_d     = count;
        err_d       = err || (state_next == ST_ERROR);
        err_code_d  = err_code;

        if (state == ST_ACCEPT && state_next == ST_WRITE) begin
            mem_wdata_d = enc_word;
            last_d      = last;
            mem_addr_d  = count[ADDR_W-1:0];
        end
        if (state == ST_WRITE) count_d = count + (ADDR_W + 1)'(1);

        if (state == ST_ACCEPT && in_valid && !enc_valid)
            err_code_d = ERR_OPCODE;
        else if (state == ST_ACCEPT && in_valid && count == FULL)
            err_code_d = ERR_OVERFLOW;
        else if (state == ST_CHECK && mismatch)
            err_code_d = ERR_VERIFY;

        if (start) begin
            count_d    = '0;
            mem_addr_d = '0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

endmodule

// File: tb/tb_opcodeenc_loader.sv
// Directed bench for opcodeenc_loader: a VERIFY=1 and a VERIFY=0 instance,
// each with its own synchronous code-memory model.
module tb_opcodeenc_loader;
    import i281_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_v = 1'b0;
    logic        start_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [26:0] op_onehot = '0;
    logic        last = 1'b0;
    logic [1:0]  reg_a = '0;
    logic [1:0]  reg_b = '0;
    logic [7:0]  imm = '0;

    logic        in_ready_v, mem_we_v, busy_v, done_v, err_v;
    logic [4:0]  mem_addr_v;
    logic [15:0] mem_wdata_v, rdata_v;
    logic [1:0]  err_code_v;
    logic [5:0]  count_v;
    state_t      state_v;

    logic        in_ready_n, mem_we_n, busy_n, done_n, err_n;
    logic [4:0]  mem_addr_n;
    logic [15:0] mem_wdata_n, rdata_n;
    logic [1:0]  err_code_n;
    logic [5:0]  count_n;
    state_t      state_n;

    logic [15:0] mem_v [32];
    logic [15:0] mem_n [32];
    logic        corrupt = 1'b0;
    int          wr_v = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    opcodeenc_loader #(.ADDR_W(5), .VERIFY(1'b1)) dut_v (
        .clk(clk), .rst_n(rst_n), .start(start_v), .in_valid(in_valid),
        .in_ready(in_ready_v), .op_onehot(op_onehot), .last(last),
        .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .mem_we(mem_we_v),
        .mem_addr(mem_addr_v), .mem_wdata(mem_wdata_v), .mem_rdata(rdata_v),
        .busy(busy_v), .done(done_v), .err(err_v), .err_code(err_code_v),
        .count(count_v), .state(state_v)
    );

    opcodeenc_loader #(.ADDR_W(5), .VERIFY(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start_n), .in_valid(in_valid),
        .in_ready(in_ready_n), .op_onehot(op_onehot), .last(last),
        .reg_a(reg_a), .reg_b(reg_b), .imm(imm), .mem_we(mem_we_n),
        .mem_addr(mem_addr_n), .mem_wdata(mem_wdata_n), .mem_rdata(rdata_n),
        .busy(busy_n), .done(done_n), .err(err_n), .err_code(err_code_n),
        .count(count_n), .state(state_n)
    );

    // Code memories: write on strobe, registered read; addr 4 can be corrupted
    always @(posedge clk) begin
        if (mem_we_v) begin
            mem_v[mem_addr_v] <= mem_wdata_v;
            wr_v <= wr_v + 1;
        end
        rdata_v <= mem_v[mem_addr_v] ^ ((corrupt && mem_addr_v == 5'd4) ? 16'h0100 : 16'h0000);
        if (mem_we_n) mem_n[mem_addr_n] <= mem_wdata_n;
        rdata_n <= mem_n[mem_addr_n];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard for the VERIFY=0 instance: every write must match the queue head
    always @(negedge clk) begin
        if (mem_we_n === 1'b1) begin
            if (exp_q.size() == 0) check("sb_unexpected_write", {16'h0, mem_wdata_n}, 32'hFFFF_FFFF);
            else check("sb_word", {16'h0, mem_wdata_n}, {16'h0, exp_q.pop_front()});
        end
    end

    function automatic logic [26:0] oh(input int i);
        logic [26:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic pulse_start(input bit which);
        @(negedge clk);
        if (which) start_n = 1'b1; else start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        start_n = 1'b0;
    endtask

    // Offer one instruction and return just after the handshake edge
    task automatic send(input bit which, input logic [26:0] op, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [7:0] im, input logic lst);
        bit got;
        got = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; op_onehot = op; reg_a = ra; reg_b = rb; imm = im; last = lst;
        for (int c = 0; c < 40; c++) begin
            if ((which ? in_ready_n : in_ready_v) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("handshake", {31'h0, got}, 32'd1);
        if (got) @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit which, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ((which ? done_n : done_v) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [26:0] bad_ops [3];
        bit seen;
        int wr_before;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready_v, 0);
        check("rst_mem_we", mem_we_v, 0);
        check("rst_mem_addr", mem_addr_v, 0);
        check("rst_mem_wdata", mem_wdata_v, 0);
        check("rst_busy", busy_v, 0);
        check("rst_done", done_v, 0);
        check("rst_err", err_v, 0);
        check("rst_err_code", err_code_v, 0);
        check("rst_count", count_v, 0);
        check("rst_state", state_v, ST_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", in_ready_v, 0);

        // ADD r1,r2 with exact VERIFY=1 timing
        pulse_start(1'b0);
        check("start_in_ready", in_ready_v, 1);
        check("start_busy", busy_v, 1);
        check("start_state", state_v, ST_ACCEPT);
        send(1'b0, oh(IDX_ADD), 2'd1, 2'd2, 8'h55, 1'b1);
        @(negedge clk);
        check("add_we_t1", mem_we_v, 1);
        check("add_addr_t1", mem_addr_v, 0);
        check("add_wdata_t1", mem_wdata_v, 16'h4600);
        check("add_state_t1", state_v, ST_WRITE);
        @(negedge clk);
        check("add_state_t2", state_v, ST_READ);
        check("add_we_t2", mem_we_v, 0);
        check("add_ready_t2", in_ready_v, 0);
        @(negedge clk);
        check("add_state_t3", state_v, ST_CHECK);
        @(negedge clk);
        check("add_done_t4", done_v, 1);
        check("add_state_t4", state_v, ST_IDLE);
        check("add_busy_t4", busy_v, 0);
        check("add_count_t4", count_v, 1);
        @(negedge clk);
        check("add_done_pulse", done_v, 0);
        check("add_mem0", mem_v[0], 16'h4600);

        // LOADI then BRGE with unused fields driven non-zero
        pulse_start(1'b0);
        send(1'b0, oh(IDX_LOADI), 2'd3, 2'd2, 8'h7F, 1'b0);
        send(1'b0, oh(IDX_BRGE), 2'd2, 2'd1, 8'hFE, 1'b1);
        wait_done(1'b0, seen);
        check("pair_done", {31'h0, seen}, 1);
        check("pair_count", count_v, 2);
        check("pair_mem0", mem_v[0], 16'h3C7F);
        check("pair_mem1", mem_v[1], 16'hF3FE);
        check("pair_err", err_v, 0);

        // Bad opcodes: zero, multi-hot, reserved bit
        bad_ops[0] = 27'h0;
        bad_ops[1] = 27'h000_0300;
        bad_ops[2] = 27'h400_0000;
        wr_before = wr_v;
        for (int k = 0; k < 3; k++) begin
            pulse_start(1'b0);
            check("bad_cleared_err", err_v, 0);
            check("bad_cleared_code", err_code_v, 0);
            send(1'b0, bad_ops[k], 2'd1, 2'd1, 8'h11, 1'b0);
            @(negedge clk);
            check("bad_err", err_v, 1);
            check("bad_code", err_code_v, 2'b01);
            check("bad_we", mem_we_v, 0);
            check("bad_state", state_v, ST_ERROR);
            check("bad_ready", in_ready_v, 0);
            check("bad_busy", busy_v, 0);
        end
        repeat (2) @(negedge clk);
        check("bad_no_writes", wr_v, wr_before);
        pulse_start(1'b0);
        check("bad_start_clears", err_v, 0);

        // Overflow: 32 writes fit, the 33rd is rejected
        wr_before = wr_v;
        for (int i = 0; i < 33; i++)
            send(1'b0, oh(IDX_ADDI), 2'(i), 2'd3, 8'(i), 1'b0);
        @(negedge clk);
        check("ovf_err", err_v, 1);
        check("ovf_code", err_code_v, 2'b10);
        check("ovf_count", count_v, 32);
        check("ovf_state", state_v, ST_ERROR);
        check("ovf_writes", wr_v - wr_before, 32);
        check("ovf_mem0", mem_v[0], 16'h5000);
        check("ovf_mem5", mem_v[5], 16'h5405);
        check("ovf_mem31", mem_v[31], 16'h5C1F);

        // Verify mismatch on read-back of address 4
        corrupt = 1'b1;
        pulse_start(1'b0);
        for (int i = 0; i < 5; i++)
            send(1'b0, oh(IDX_SUBI), 2'(i), 2'd0, 8'(i + 8), 1'b0);
        repeat (5) @(negedge clk);
        check("vfy_err", err_v, 1);
        check("vfy_code", err_code_v, 2'b11);
        check("vfy_count", count_v, 5);
        check("vfy_state", state_v, ST_ERROR);
        corrupt = 1'b0;

        // VERIFY=0 instance: fast return of in_ready and done after last write
        exp_q.push_back(16'h1912);
        exp_q.push_back(16'hB780);
        exp_q.push_back(16'hC900);
        exp_q.push_back(16'hE020);
        exp_q.push_back(16'h2D00);
        pulse_start(1'b1);
        send(1'b1, oh(IDX_INPUTCF), 2'd2, 2'd3, 8'h12, 1'b0);
        @(negedge clk);
        check("nv_we_t1", mem_we_n, 1);
        check("nv_addr_t1", mem_addr_n, 0);
        @(negedge clk);
        check("nv_ready_t2", in_ready_n, 1);
        check("nv_count_t2", count_n, 1);
        send(1'b1, oh(IDX_STOREF), 2'd1, 2'd3, 8'h80, 1'b0);
        send(1'b1, oh(IDX_SHIFTR), 2'd2, 2'd3, 8'hFF, 1'b0);
        send(1'b1, oh(IDX_JUMP), 2'd3, 2'd3, 8'h20, 1'b0);
        send(1'b1, oh(IDX_MOVE), 2'd3, 2'd1, 8'hAA, 1'b1);
        @(negedge clk);
        check("nv_last_addr", mem_addr_n, 4);
        @(negedge clk);
        check("nv_done", done_n, 1);
        check("nv_count", count_n, 5);
        check("nv_err", err_n, 0);
        check("nv_state", state_n, ST_IDLE);
        check("nv_mem4", mem_n[4], 16'h2D00);
        check("sb_drained", exp_q.size(), 0);

        // Reset asserted during WRITE takes effect immediately
        pulse_start(1'b0);
        send(1'b0, oh(IDX_NOOP), 2'd3, 2'd3, 8'hFF, 1'b0);
        @(negedge clk);
        check("rw_we_before", mem_we_v, 1);
        rst_n = 1'b0;
        #1;
        check("rw_we", mem_we_v, 0);
        check("rw_state", state_v, ST_IDLE);
        check("rw_busy", busy_v, 0);
        check("rw_ready", in_ready_v, 0);
        check("rw_count", count_v, 0);
        check("rw_addr", mem_addr_v, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start during a session's second WRITE restarts at address 0
        pulse_start(1'b0);
        send(1'b0, oh(IDX_ADD), 2'd0, 2'd1, 8'h00, 1'b0);
        send(1'b0, oh(IDX_SUB), 2'd2, 2'd3, 8'h77, 1'b0);
        @(negedge clk);
        check("rs_we", mem_we_v, 1);
        check("rs_addr", mem_addr_v, 1);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        check("rs_count", count_v, 0);
        check("rs_ready", in_ready_v, 1);
        check("rs_we_off", mem_we_v, 0);
        check("rs_strobe_done", mem_v[1], 16'h6B00);
        send(1'b0, oh(IDX_LOADP), 2'd1, 2'd2, 8'h44, 1'b1);
        @(negedge clk);
        check("rs_new_addr", mem_addr_v, 0);
        wait_done(1'b0, seen);
        check("rs_done", {31'h0, seen}, 1);
        check("rs_mem0", mem_v[0], 16'h3544);
        check("rs_final_count", count_v, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
